sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
Parametrised single-clock FIFO, the successor to the existing 16x8 synchronous FIFO. Adds:
- arbitrary (non-power-of-two) depth
- correct simultaneous read/write at every fill level
- fill count, programmable almost-full/almost-empty flags, synchronous flush
- selectable standard or first-word-fall-through (FWFT) read mode
Sits between producer/consumer stages on a common clock and is the default buffer for new datapaths.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries (>=2; power of two not required)
FWFT, 0, 0 = standard read (data one cycle after rd_en_i); 1 = head word visible on rd_data_o while not empty
AF_THRESH, DEPTH-2, almost_full_o asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty_o asserted when count <= AE_THRESH
(local) PTR_W = max(1,$clog2(DEPTH)); CNT_W = $clog2(DEPTH+1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
flush_i  in  1  synchronous flush, empties FIFO
wr_en_i  in  1  write request
wr_data_i  in  WIDTH  write data
rd_en_i  in  1  read request
rd_data_o  out  WIDTH  read data
rd_valid_o  out  1  standard mode: rd_data_o updated this cycle; FWFT: equals !empty
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AF_THRESH
almost_empty_o  out  1  count <= AE_THRESH
count_o  out  CNT_W  current occupancy 0..DEPTH
wr_error_o  out  1  one-cycle pulse: write rejected
rd_error_o  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (async assert, sync release): pointers=0, count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=(AF_THRESH==0), rd_data_o=0, rd_valid_o=0, errors=0. Memory contents not reset.
- Accept rules, evaluated on registered state at the clock edge:
  - wr_acc = wr_en_i & (!full_o | rd_acc)
  - rd_acc = rd_en_i & !empty_o
  - Reading while full frees a slot, so a simultaneous write is accepted; writing while empty does not make a read valid.
- count_next = count + wr_acc - rd_acc; full/empty/almost flags are registered from count_next, so they are valid in the same cycle as count_o.
- Pointers: increment on accept; wrap from DEPTH-1 to 0 explicitly (no reliance on natural overflow).
- Standard mode: on rd_acc, rd_data_o <= mem[rd_ptr] and rd_valid_o=1 next cycle; otherwise rd_data_o holds and rd_valid_o=0.
- FWFT mode: rd_data_o = mem[rd_ptr] combinationally whenever !empty_o; rd_en_i pops the head. A word written to an empty FIFO appears one cycle after the write edge.
- Errors: wr_error_o=1 for the cycle after wr_en_i & !wr_acc; rd_error_o=1 for the cycle after rd_en_i & !rd_acc; otherwise 0. No state change on a rejected request.
- Flush: highest priority below reset. Pointers and count go to 0 and flags take their reset values. wr/rd in the same cycle are ignored with no error pulse. rd_data_o holds; rd_valid_o=0.
- Reset mid-operation: immediate return to reset state; in-flight requests are lost.

Decomposition:
- Package sync_fifo_pkg: ptr_inc wrap function, flag-compare helpers, default threshold constants.
- One sub-module, sync_fifo_ram: DEPTH x WIDTH storage with a synchronous write port and an asynchronous read port. Control (pointers, count, flags, errors, mode mux) stays in the top level.

Test Plan:
- Reset, write 0x01..0x10 (DEPTH=16) -> full_o=1 at count 16, almost_full_o from count 14; 17th write -> wr_error_o pulse, count stays 16.
- Full FIFO, wr_en_i & rd_en_i with 0xAA -> read returns 0x01, count stays 16, full_o stays 1, 0xAA is read last.
- Empty FIFO, wr_en_i & rd_en_i -> write accepted, rd_error_o pulse, count=1.
- DEPTH=5: 12 writes/reads interleaved -> pointers wrap at 4, data order preserved.
- FWFT=1: write 0x5A to empty -> rd_data_o=0x5A with empty_o=0 one cycle later, no rd_en_i needed.
- Count 9, flush_i with wr_en_i -> count_o=0, empty_o=1, no wr_error_o; rst_i pulse mid-burst -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the flexible synchronous FIFO: pointer wrap, flag compares, defaults.
package sync_fifo_pkg;

    localparam int unsigned DefaultWidth    = 8;
    localparam int unsigned DefaultDepth    = 16;
    localparam int unsigned DefaultAeThresh = 2;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic logic cnt_at_least(input int unsigned cnt, input int unsigned thresh);
        return cnt >= thresh;
    endfunction

    function automatic logic cnt_at_most(input int unsigned cnt, input int unsigned thresh);
        return cnt <= thresh;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port, no reset.
module sync_fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with fill count, almost flags, flush and optional FWFT reads.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = DefaultAeThresh,
    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             wr_error_o,
    output logic             rd_error_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             wr_err_q, wr_err_d;
    logic             rd_err_q, rd_err_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] ram_rdata;
    logic             wr_acc;
    logic             rd_acc;

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        // A read of a full FIFO frees a slot, so it lets a same-cycle write through.
        rd_acc = rd_en_i & ~empty_q & ~flush_i;
        wr_acc = wr_en_i & (~full_q | rd_acc) & ~flush_i;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
            end
            count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end

        full_d  = cnt_at_least(32'(count_d), DEPTH);
        empty_d = cnt_at_most(32'(count_d), 0);
        af_d    = cnt_at_least(32'(count_d), AF_THRESH);
        ae_d    = cnt_at_most(32'(count_d), AE_THRESH);

        wr_err_d   = wr_en_i & ~wr_acc & ~flush_i;
        rd_err_d   = rd_en_i & ~rd_acc & ~flush_i;
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? ram_rdata : rd_data_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= (AF_THRESH == 0);
            ae_q       <= 1'b1;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            wr_err_q   <= wr_err_d;
            rd_err_q   <= rd_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // FWFT shows the head word directly; when empty it falls back to the last popped word.
    if (FWFT != 0) begin : g_fwft
        assign rd_data_o  = empty_q ? rd_data_q : ram_rdata;
        assign rd_valid_o = ~empty_q;
    end else begin : g_std
        assign rd_data_o  = rd_data_q;
        assign rd_valid_o = rd_valid_q;
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign count_o        = count_q;
    assign wr_error_o     = wr_err_q;
    assign rd_error_o     = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench: vector table plus scoreboard on a 16-deep, 5-deep and FWFT FIFO.
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 16-deep standard-mode instance
    logic       wr16 = 0, rd16 = 0, fl16 = 0;
    logic [7:0] wd16 = 0, rdata16;
    logic       rdv16, full16, empty16, af16, ae16, werr16, rerr16;
    logic [4:0] cnt16;

    // 5-deep standard-mode instance
    logic       wr5 = 0, rd5 = 0;
    logic [7:0] wd5 = 0, rdata5;
    logic       rdv5, full5, empty5, af5, ae5, werr5, rerr5;
    logic [2:0] cnt5;

    // 4-deep FWFT instance
    logic       wrf = 0, rdf = 0;
    logic [7:0] wdf = 0, rdataf;
    logic       rdvf, fullf, emptyf, aff, aef, werrf, rerrf;
    logic [2:0] cntf;

    sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_d16 (
        .clk_i(clk), .rst_i(rst), .flush_i(fl16), .wr_en_i(wr16), .wr_data_i(wd16),
        .rd_en_i(rd16), .rd_data_o(rdata16), .rd_valid_o(rdv16), .full_o(full16),
        .empty_o(empty16), .almost_full_o(af16), .almost_empty_o(ae16), .count_o(cnt16),
        .wr_error_o(werr16), .rd_error_o(rerr16)
    );

    sync_fifo_flex #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_d5 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .wr_en_i(wr5), .wr_data_i(wd5),
        .rd_en_i(rd5), .rd_data_o(rdata5), .rd_valid_o(rdv5), .full_o(full5),
        .empty_o(empty5), .almost_full_o(af5), .almost_empty_o(ae5), .count_o(cnt5),
        .wr_error_o(werr5), .rd_error_o(rerr5)
    );

    sync_fifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_fw (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .wr_en_i(wrf), .wr_data_i(wdf),
        .rd_en_i(rdf), .rd_data_o(rdataf), .rd_valid_o(rdvf), .full_o(fullf),
        .empty_o(emptyf), .almost_full_o(aff), .almost_empty_o(aef), .count_o(cntf),
        .wr_error_o(werrf), .rd_error_o(rerrf)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic       fl;
        logic [7:0] din;
        int         cnt;
        logic       werr;
        logic       rerr;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] q16[$];
    logic [7:0] q5[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flag expectations for the 16-deep instance (AF=14, AE=2), derived from the count.
    task automatic chk_flags16(input int c);
        chk("cnt16", cnt16, c);
        chk("full16", full16, c == 16);
        chk("empty16", empty16, c == 0);
        chk("af16", af16, c >= 14);
        chk("ae16", ae16, c <= 2);
    endtask

    task automatic pop16();
        if (rdv16) begin
            if (q16.size() == 0) begin
                chk("sb16_underflow", 1, 0);
            end else begin
                chk("rdata16", rdata16, q16.pop_front());
            end
        end
    endtask

    task automatic pop5();
        chk("rdv5", rdv5, 1);
        if (q5.size() == 0) begin
            chk("sb5_underflow", 1, 0);
        end else begin
            chk("rdata5", rdata5, q5.pop_front());
        end
    endtask

    initial begin
        int c5;

        for (int i = 0; i < 16; i++) vecs.push_back('{1'b1, 1'b0, 1'b0, 8'(i + 1), i + 1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h11, 16, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'hAA, 16, 1'b0, 1'b0});
        for (int i = 0; i < 16; i++) vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 15 - i, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h33, 1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b0});

        repeat (2) tick();
        chk_flags16(0);
        chk("rst_rdata16", rdata16, 0);
        chk("rst_rdv16", rdv16, 0);
        chk("rst_werr16", werr16, 0);
        chk("rst_rerr16", rerr16, 0);
        chk("rst_rdvf", rdvf, 0);
        chk("rst_emptyf", emptyf, 1);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            wr16 = vecs[i].wr;
            rd16 = vecs[i].rd;
            fl16 = vecs[i].fl;
            wd16 = vecs[i].din;
            if (vecs[i].wr && !vecs[i].werr && !vecs[i].fl) q16.push_back(vecs[i].din);
            tick();
            chk_flags16(vecs[i].cnt);
            chk("werr16", werr16, vecs[i].werr);
            chk("rerr16", rerr16, vecs[i].rerr);
            chk("rdv16", rdv16, vecs[i].rd && !vecs[i].rerr && !vecs[i].fl);
            pop16();
        end
        wr16 = 0;
        rd16 = 0;
        chk("sb16_drained", q16.size(), 0);

        // Flush at count 9 with a concurrent write and read: nothing accepted, no errors.
        for (int i = 0; i < 9; i++) begin
            wr16 = 1;
            wd16 = 8'(8'h60 + i);
            tick();
        end
        wr16 = 0;
        chk_flags16(9);
        wr16 = 1;
        rd16 = 1;
        fl16 = 1;
        wd16 = 8'h77;
        tick();
        wr16 = 0;
        rd16 = 0;
        fl16 = 0;
        chk_flags16(0);
        chk("flush_werr", werr16, 0);
        chk("flush_rerr", rerr16, 0);
        chk("flush_rdv", rdv16, 0);
        wr16 = 1;
        wd16 = 8'h88;
        tick();
        wr16 = 0;
        rd16 = 1;
        tick();
        rd16 = 0;
        chk("post_flush_rdv", rdv16, 1);
        chk("post_flush_data", rdata16, 8'h88);
        chk_flags16(0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) begin
            wr16 = 1;
            wd16 = 8'(8'h90 + i);
            tick();
        end
        wr16 = 0;
        rd16 = 1;
        tick();
        chk("pre_rst_data", rdata16, 8'h90);
        wr16 = 1;
        wd16 = 8'hEE;
        #2;
        rst = 1'b1;
        wr16 = 0;
        rd16 = 0;
        #1;
        chk_flags16(0);
        chk("arst_rdata16", rdata16, 0);
        chk("arst_rdv16", rdv16, 0);
        chk("arst_werr16", werr16, 0);
        #2;
        rst = 1'b0;
        tick();
        chk_flags16(0);

        // DEPTH=5: fill, stream through while full, drain; pointers wrap twice.
        c5 = 0;
        for (int i = 0; i < 12; i++) begin
            wr5 = 1;
            rd5 = (i >= 5);
            wd5 = 8'(8'h40 + i);
            q5.push_back(wd5);
            tick();
            if (i >= 5) pop5();
            else c5++;
            chk("cnt5", cnt5, c5);
            chk("werr5", werr5, 0);
            if (i >= 4) chk("full5", full5, 1);
        end
        wr5 = 0;
        for (int i = 0; i < 5; i++) begin
            rd5 = 1;
            tick();
            pop5();
            c5--;
            chk("cnt5_drain", cnt5, c5);
            chk("full5_drain", full5, 0);
        end
        rd5 = 0;
        chk("empty5", empty5, 1);

        // FWFT: head word visible one cycle after writing to an empty FIFO.
        wrf = 1;
        wdf = 8'h5A;
        tick();
        wrf = 0;
        chk("fw_empty", emptyf, 0);
        chk("fw_data", rdataf, 8'h5A);
        chk("fw_rdv", rdvf, 1);
        wrf = 1;
        wdf = 8'h5B;
        tick();
        wrf = 0;
        chk("fw_head_hold", rdataf, 8'h5A);
        chk("fw_cnt2", cntf, 2);
        rdf = 1;
        tick();
        chk("fw_pop_data", rdataf, 8'h5B);
        chk("fw_cnt1", cntf, 1);
        tick();
        rdf = 0;
        chk("fw_empty_end", emptyf, 1);
        chk("fw_rdv_end", rdvf, 0);
        chk("fw_cnt0", cntf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
